// File: rtl/crypto_cmd_dispatcher.sv
// Command queue and sequencer in front of the AES and PRNG engines.
// Tagged jobs are queued in a small FIFO and issued one at a time. Each job
// gets a one-cycle start pulse, then waits for its engine's done pulse or a
// timeout, and finally presents a tagged completion record to the host.
//
// Handshakes: a transfer happens on a rising clock edge where valid && ready.
// The command side offers {cmd_engine, cmd_tag} with cmd_valid, and the
// dispatcher accepts when cmd_ready (FIFO not full). The completion side holds
// cpl_tag/cpl_engine/cpl_timeout stable while cpl_valid && !cpl_ready.
module crypto_cmd_dispatcher #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_engine,
    input  logic [TAG_W-1:0]         cmd_tag,
    output logic                     aes_start,
    input  logic                     aes_done,
    output logic                     prng_start,
    input  logic                     prng_done,
    output logic                     cpl_valid,
    input  logic                     cpl_ready,
    output logic [TAG_W-1:0]         cpl_tag,
    output logic                     cpl_engine,
    output logic                     cpl_timeout,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic                     idle
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    // The wait counter only has to reach TIMEOUT-1.
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_CPL   = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [TAG_W:0]    mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              push, pop;
    logic              job_engine;
    logic [TAG_W-1:0]  job_tag;
    logic [TO_W-1:0]   wait_cnt, wait_cnt_n;
    logic              cpl_load, cpl_timeout_n, sel_done;

    assign cmd_ready   = (count != CW'(DEPTH));
    assign push        = cmd_valid && cmd_ready;
    // The FSM leaves IDLE exactly when it takes the FIFO head.
    assign pop         = (state == S_IDLE) && (count != '0);
    assign queue_count = count;
    assign cpl_valid   = (state == S_CPL);
    assign idle        = (count == '0) && (state == S_IDLE);

    // FIFO storage: written on push, no reset needed for the data itself.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_engine, cmd_tag};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Next-state, start pulses and completion capture decisions.
    always_comb begin
        state_n       = state;
        wait_cnt_n    = wait_cnt;
        cpl_load      = 1'b0;
        cpl_timeout_n = 1'b0;
        aes_start     = 1'b0;
        prng_start    = 1'b0;
        sel_done      = job_engine ? prng_done : aes_done;
        case (state)
            S_IDLE: begin
                if (count != '0) state_n = S_ISSUE;
            end
            S_ISSUE: begin
                aes_start  = !job_engine;
                prng_start = job_engine;
                wait_cnt_n = '0;
                state_n    = S_WAIT;
            end
            S_WAIT: begin
                // A done on the final wait cycle beats the timeout.
                if (sel_done) begin
                    cpl_load      = 1'b1;
                    cpl_timeout_n = 1'b0;
                    state_n       = S_CPL;
                end else if (wait_cnt == WAIT_LAST) begin
                    cpl_load      = 1'b1;
                    cpl_timeout_n = 1'b1;
                    state_n       = S_CPL;
                end else begin
                    wait_cnt_n = wait_cnt + TO_W'(1);
                end
            end
            S_CPL: begin
                if (cpl_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State, wait counter, job register and completion record registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            job_engine  <= 1'b0;
            job_tag     <= '0;
            cpl_tag     <= '0;
            cpl_engine  <= 1'b0;
            cpl_timeout <= 1'b0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            if (pop) begin
                {job_engine, job_tag} <= mem[rd_ptr];
            end
            if (cpl_load) begin
                cpl_tag     <= job_tag;
                cpl_engine  <= job_engine;
                cpl_timeout <= cpl_timeout_n;
            end
        end
    end

endmodule

// File: tb/tb_crypto_cmd_dispatcher.sv
// Bench for crypto_cmd_dispatcher: directed scenarios with literal
// expectations, plus a queue-based reference model compared every cycle.
module tb_crypto_cmd_dispatcher;

    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 8;

    logic             clock;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_engine;
    logic [TAG_W-1:0] cmd_tag;
    logic             aes_start;
    logic             aes_done;
    logic             prng_start;
    logic             prng_done;
    logic             cpl_valid;
    logic             cpl_ready;
    logic [TAG_W-1:0] cpl_tag;
    logic             cpl_engine;
    logic             cpl_timeout;
    logic [$clog2(DEPTH):0] queue_count;
    logic             idle;

    crypto_cmd_dispatcher #(
        .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_engine(cmd_engine), .cmd_tag(cmd_tag),
        .aes_start(aes_start), .aes_done(aes_done),
        .prng_start(prng_start), .prng_done(prng_done),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready),
        .cpl_tag(cpl_tag), .cpl_engine(cpl_engine), .cpl_timeout(cpl_timeout),
        .queue_count(queue_count), .idle(idle)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Jobs are tracked by timestamps: a job popped at the end of cycle c is
    // issued in cycle c+1 and may complete on any of the following TIMEOUT
    // cycles; the last of those without a done is a timeout.
    typedef struct packed {
        logic             eng;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    cmd_t             m_q[$];
    bit               m_have = 0;
    cmd_t             m_job;
    int               m_issue = 0;
    bit               m_cpl = 0;
    logic [TAG_W-1:0] m_tag;
    logic             m_eng;
    logic             m_to;
    int               m_cyc = 0;
    bit               chk_en = 0;
    int               m_old_size;
    bit               m_push;
    logic             m_sel_done;

    always @(posedge clock) begin
        if (reset) begin
            m_q.delete();
            m_have = 0;
            m_cpl  = 0;
            m_tag  = '0;
            m_eng  = 1'b0;
            m_to   = 1'b0;
            chk_en = 1;
        end else begin
            m_old_size = m_q.size();
            m_push     = cmd_valid && (m_old_size < DEPTH);
            if (m_cpl) begin
                if (cpl_ready) m_cpl = 0;
            end else if (m_have) begin
                if (m_cyc > m_issue) begin
                    m_sel_done = m_job.eng ? prng_done : aes_done;
                    if (m_sel_done || (m_cyc - m_issue) >= TIMEOUT) begin
                        m_have = 0;
                        m_cpl  = 1;
                        m_tag  = m_job.tag;
                        m_eng  = m_job.eng;
                        m_to   = !m_sel_done;
                    end
                end
            end else if (m_old_size > 0) begin
                m_job   = m_q.pop_front();
                m_have  = 1;
                m_issue = m_cyc + 1;
            end
            if (m_push) m_q.push_back(cmd_t'({cmd_engine, cmd_tag}));
        end
        m_cyc++;
    end

    // Compare every DUT output against the model on the falling edge.
    always @(negedge clock) begin
        if (chk_en) begin
            check("cmd_ready",   32'(cmd_ready),   32'(m_q.size() < DEPTH));
            check("queue_count", 32'(queue_count), 32'(m_q.size()));
            check("aes_start",   32'(aes_start),   32'(m_have && m_cyc == m_issue && !m_job.eng));
            check("prng_start",  32'(prng_start),  32'(m_have && m_cyc == m_issue && m_job.eng));
            check("cpl_valid",   32'(cpl_valid),   32'(m_cpl));
            check("cpl_tag",     32'(cpl_tag),     32'(m_tag));
            check("cpl_engine",  32'(cpl_engine),  32'(m_eng));
            check("cpl_timeout", 32'(cpl_timeout), 32'(m_to));
            check("idle",        32'(idle),        32'(m_q.size() == 0 && !m_have && !m_cpl));
        end
    end

    // ---------------- driver tasks ----------------
    logic [TAG_W:0] exp_q[$];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic eng, input logic [TAG_W-1:0] tag);
        cmd_valid  = 1'b1;
        cmd_engine = eng;
        cmd_tag    = tag;
        tick();
        cmd_valid  = 1'b0;
    endtask

    // Advance until the requested start pulse is seen (bounded).
    task automatic wait_start(input logic eng, input string name, output int n);
        n = 0;
        while (((eng ? prng_start : aes_start) !== 1'b1) && n < 30) begin
            tick();
            n++;
        end
        check(name, 32'((eng ? prng_start : aes_start) === 1'b1), 32'd1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int n;
        int ncpl;
        logic [TAG_W:0] exp_rec;

        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_engine = 1'b0;
        cmd_tag    = '0;
        aes_done   = 1'b0;
        prng_done  = 1'b0;
        cpl_ready  = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state.
        check("rst_cmd_ready",   32'(cmd_ready),   32'd1);
        check("rst_idle",        32'(idle),        32'd1);
        check("rst_queue_count", 32'(queue_count), 32'd0);
        check("rst_cpl_valid",   32'(cpl_valid),   32'd0);
        check("rst_cpl_tag",     32'(cpl_tag),     32'd0);

        // Single AES job: start 2 cycles after the push, done after 4 wait cycles.
        push(1'b0, 4'd3);
        wait_start(1'b0, "t1_start_seen", n);
        check("t1_push_to_start", 32'(n + 1), 32'd2);
        tick();
        check("t1_start_width", 32'(aes_start), 32'd0);
        repeat (3) tick();
        aes_done = 1'b1;
        tick();
        aes_done = 1'b0;
        check("t1_cpl_valid",   32'(cpl_valid),   32'd1);
        check("t1_cpl_tag",     32'(cpl_tag),     32'd3);
        check("t1_cpl_engine",  32'(cpl_engine),  32'd0);
        check("t1_cpl_timeout", 32'(cpl_timeout), 32'd0);
        tick();
        check("t1_idle_again",  32'(idle),        32'd1);

        // Fill the FIFO behind one in-flight job; the sixth command is dropped.
        cpl_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            cmd_valid  = 1'b1;
            cmd_engine = i[0];
            cmd_tag    = TAG_W'(i);
            exp_q.push_back({i[0], TAG_W'(i)});
            tick();
        end
        cmd_valid = 1'b0;
        check("t2_queue_full",  32'(queue_count), 32'd4);
        check("t2_cmd_ready",   32'(cmd_ready),   32'd0);
        cmd_valid  = 1'b1;
        cmd_engine = 1'b0;
        cmd_tag    = 4'd6;
        tick();
        cmd_valid = 1'b0;
        check("t2_drop_count",  32'(queue_count), 32'd4);
        cpl_ready = 1'b1;
        ncpl = 0;
        for (int c = 0; c < 150; c++) begin
            if (cpl_valid === 1'b1) begin
                ncpl++;
                exp_rec = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                check("t2_cpl_order", 32'({cpl_engine, cpl_tag}), 32'(exp_rec));
                check("t2_cpl_timeout", 32'(cpl_timeout), 32'd1);
            end
            tick();
        end
        check("t2_cpl_count", 32'(ncpl), 32'd5);
        check("t2_idle",      32'(idle), 32'd1);

        // PRNG job that never finishes: timeout 9 cycles after the ISSUE cycle.
        push(1'b1, 4'd9);
        wait_start(1'b1, "t3_start_seen", n);
        n = 0;
        while (cpl_valid !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check("t3_issue_to_cpl", 32'(n),           32'd9);
        check("t3_cpl_timeout",  32'(cpl_timeout), 32'd1);
        check("t3_cpl_engine",   32'(cpl_engine),  32'd1);
        check("t3_cpl_tag",      32'(cpl_tag),     32'd9);
        tick();
        prng_done = 1'b1;
        tick();
        prng_done = 1'b0;
        repeat (3) begin
            check("t3_no_extra_cpl", 32'(cpl_valid), 32'd0);
            tick();
        end

        // Done on the same cycle the timeout would fire: done wins.
        push(1'b0, 4'd5);
        wait_start(1'b0, "t4_start_seen", n);
        repeat (8) tick();
        aes_done = 1'b1;
        tick();
        aes_done = 1'b0;
        check("t4_cpl_valid",   32'(cpl_valid),   32'd1);
        check("t4_cpl_timeout", 32'(cpl_timeout), 32'd0);
        tick();

        // AES job ignores prng_done and completes on aes_done.
        push(1'b0, 4'd11);
        wait_start(1'b0, "t5_start_seen", n);
        repeat (2) tick();
        prng_done = 1'b1;
        tick();
        prng_done = 1'b0;
        check("t5_wrong_done", 32'(cpl_valid), 32'd0);
        repeat (2) tick();
        aes_done = 1'b1;
        tick();
        aes_done = 1'b0;
        check("t5_cpl_valid",   32'(cpl_valid),   32'd1);
        check("t5_cpl_timeout", 32'(cpl_timeout), 32'd0);
        check("t5_cpl_tag",     32'(cpl_tag),     32'd11);
        tick();

        // Reset while waiting with two jobs queued.
        cmd_engine = 1'b0;
        cmd_valid  = 1'b1;
        cmd_tag    = 4'd7;
        tick();
        cmd_tag    = 4'd8;
        tick();
        cmd_tag    = 4'd10;
        tick();
        cmd_valid = 1'b0;
        check("t6_pre_count", 32'(queue_count), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_count",     32'(queue_count), 32'd0);
        check("t6_idle",      32'(idle),        32'd1);
        check("t6_cpl_valid", 32'(cpl_valid),   32'd0);
        aes_done = 1'b1;
        tick();
        aes_done = 1'b0;
        repeat (3) begin
            check("t6_late_done", 32'(cpl_valid), 32'd0);
            check("t6_no_start",  32'(aes_start), 32'd0);
            tick();
        end
        push(1'b0, 4'd12);
        wait_start(1'b0, "t6_fresh_start", n);
        tick();
        aes_done = 1'b1;
        tick();
        aes_done = 1'b0;
        check("t6_fresh_cpl", 32'(cpl_valid), 32'd1);
        check("t6_fresh_tag", 32'(cpl_tag),   32'd12);
        tick();
        check("t6_fresh_idle", 32'(idle), 32'd1);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
